axilite_console_slave: RTL

- AXI4-Lite responder (slave) terminating the uncore MMIO master port; presents a UART-lite-compatible console register map.
- Bridges CPU loads/stores to a byte-wide TX stream (to the host-side console) and an RX stream (from the host).
- Contains independent TX and RX byte FIFOs plus an interrupt pulse routed into the core interrupt vector.

---
 rtl/console_pkg.sv | 37 +++
 rtl/byte_fifo.sv | 50 +++++
 rtl/axilite_console_slave.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - register map, status/control bit positions and response codes for the console slave
package console_pkg;

  localparam logic [1:0] REG_RX   = 2'd0;
  localparam logic [1:0] REG_TX   = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_INTR_EN  = 4;
  localparam int STAT_OVERRUN  = 5;

  localparam int CTRL_TX_CLR  = 0;
  localparam int CTRL_RX_CLR  = 1;
  localparam int CTRL_INTR_EN = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Parity and frame error bits are never raised by this console.
  function automatic logic [7:0] stat_pack(input logic overrun, input logic intr_en,
                                           input logic tx_full, input logic tx_empty,
                                           input logic rx_full, input logic rx_valid);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_OVERRUN]  = overrun;
    s[STAT_INTR_EN]  = intr_en;
    s[STAT_TX_FULL]  = tx_full;
    s[STAT_TX_EMPTY] = tx_empty;
    s[STAT_RX_FULL]  = rx_full;
    s[STAT_RX_VALID] = rx_valid;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous byte FIFO with push/pop/clear and zero-latency head
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  input  logic       clear,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axilite_console_slave.sv
// rtl/axilite_console_slave.sv - AXI4-Lite console register slave bridging MMIO to TX/RX byte streams
module axilite_console_slave
  import console_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  uncoreclk,
  input  logic                  uncore_rstn,
  input  logic [ADDR_WIDTH-1:0] s_axilite_awaddr,
  input  logic                  s_axilite_awvalid,
  output logic                  s_axilite_awready,
  input  logic [31:0]           s_axilite_wdata,
  input  logic [3:0]            s_axilite_wstrb,
  input  logic                  s_axilite_wvalid,
  output logic                  s_axilite_wready,
  output logic [1:0]            s_axilite_bresp,
  output logic                  s_axilite_bvalid,
  input  logic                  s_axilite_bready,
  input  logic [ADDR_WIDTH-1:0] s_axilite_araddr,
  input  logic                  s_axilite_arvalid,
  output logic                  s_axilite_arready,
  output logic [31:0]           s_axilite_rdata,
  output logic [1:0]            s_axilite_rresp,
  output logic                  s_axilite_rvalid,
  input  logic                  s_axilite_rready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  intr
);

  logic       rdy_en, aw_held, w_held, w_strb0;
  logic [1:0] aw_idx, ar_idx;
  logic [7:0] w_byte;
  logic       aw_hs, w_hs, ar_hs, wr_exec;
  logic       ctrl_wr, tx_clr, rx_clr, tx_push, tx_pop, rx_pop;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] rx_head;
  logic       intr_en, overrun, overrun_evt;
  logic       rx_empty_d, tx_empty_d, tx_clr_d, rx_rise, tx_fall;
  logic [31:0] rd_value;
  logic       unused_bits;

  assign unused_bits = ^{s_axilite_awaddr[ADDR_WIDTH-1:4], s_axilite_awaddr[1:0],
                         s_axilite_araddr[ADDR_WIDTH-1:4], s_axilite_araddr[1:0],
                         s_axilite_wdata[31:8], s_axilite_wstrb[3:1]};

  // rdy_en keeps every ready low for the first cycle out of reset.
  assign s_axilite_awready = rdy_en && !aw_held && !s_axilite_bvalid;
  assign s_axilite_wready  = rdy_en && !w_held && !s_axilite_bvalid;
  assign s_axilite_arready = rdy_en && !s_axilite_rvalid;
  assign s_axilite_bresp   = RESP_OKAY;
  assign s_axilite_rresp   = RESP_OKAY;
  assign rx_ready          = 1'b1;

  assign aw_hs   = s_axilite_awvalid && s_axilite_awready;
  assign w_hs    = s_axilite_wvalid && s_axilite_wready;
  assign ar_hs   = s_axilite_arvalid && s_axilite_arready;
  assign wr_exec = aw_held && w_held;
  assign ar_idx  = s_axilite_araddr[3:2];

  assign ctrl_wr     = wr_exec && (aw_idx == REG_CTRL) && w_strb0;
  assign tx_clr      = ctrl_wr && w_byte[CTRL_TX_CLR];
  assign rx_clr      = ctrl_wr && w_byte[CTRL_RX_CLR];
  assign tx_push     = wr_exec && (aw_idx == REG_TX) && w_strb0;
  assign tx_valid    = !tx_empty;
  assign tx_pop      = tx_valid && tx_ready;
  assign rx_pop      = ar_hs && (ar_idx == REG_RX) && !rx_empty;
  assign overrun_evt = rx_valid && rx_full && !rx_pop;

  always_comb begin
    rd_value = 32'h0;
    case (ar_idx)
      REG_RX:   rd_value = rx_empty ? 32'h0 : {24'h0, rx_head};
      REG_STAT: rd_value = {24'h0, stat_pack(overrun, intr_en, tx_full, tx_empty, rx_full, !rx_empty)};
      default:  rd_value = 32'h0;
    endcase
  end

  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      rdy_en           <= 1'b0;
      aw_held          <= 1'b0;
      w_held           <= 1'b0;
      aw_idx           <= 2'd0;
      w_byte           <= 8'h00;
      w_strb0          <= 1'b0;
      s_axilite_bvalid <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (wr_exec) begin
        aw_held          <= 1'b0;
        w_held           <= 1'b0;
        s_axilite_bvalid <= 1'b1;
      end else if (s_axilite_bvalid && s_axilite_bready) begin
        s_axilite_bvalid <= 1'b0;
      end
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axilite_awaddr[3:2];
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        w_byte  <= s_axilite_wdata[7:0];
        w_strb0 <= s_axilite_wstrb[0];
      end
    end
  end

  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      s_axilite_rvalid <= 1'b0;
      s_axilite_rdata  <= 32'h0;
    end else if (ar_hs) begin
      s_axilite_rvalid <= 1'b1;
      s_axilite_rdata  <= rd_value;
    end else if (s_axilite_rvalid && s_axilite_rready) begin
      s_axilite_rvalid <= 1'b0;
    end
  end

  // Edges are detected one cycle late against registered empties; a cleared TX never interrupts.
  assign rx_rise = rx_empty_d && !rx_empty;
  assign tx_fall = !tx_empty_d && tx_empty && !tx_clr_d;

  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      intr_en    <= 1'b0;
      overrun    <= 1'b0;
      intr       <= 1'b0;
      rx_empty_d <= 1'b1;
      tx_empty_d <= 1'b1;
      tx_clr_d   <= 1'b0;
    end else begin
      if (ctrl_wr) intr_en <= w_byte[CTRL_INTR_EN];
      if (overrun_evt) overrun <= 1'b1;
      else if (ar_hs && (ar_idx == REG_STAT)) overrun <= 1'b0;
      intr       <= intr_en && (rx_rise || tx_fall);
      rx_empty_d <= rx_empty;
      tx_empty_d <= tx_empty;
      tx_clr_d   <= tx_clr;
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (uncoreclk),
    .rst_n     (uncore_rstn),
    .push      (tx_push),
    .push_data (w_byte),
    .pop       (tx_pop),
    .clear     (tx_clr),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (tx_data)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (uncoreclk),
    .rst_n     (uncore_rstn),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_pop),
    .clear     (rx_clr),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_head)
  );

endmodule
